// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage
//                and the pipeline registers that follow it.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // Default encoding that stops instruction fetch.
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Bubble written into a pipeline register on flush.
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    // Bytes per instruction word; PC increment.
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if_id_register.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_register
//  Description : IF/ID pipeline register holding valid, instruction, pc and
//                pc+4. Flush beats load, load beats clear; with no control
//                asserted the contents hold (stall).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,          // synchronous, active-low
    input  logic        i_clear,      // drop valid, keep payload
    input  logic        i_flush,      // drop valid and bubble the instruction
    input  logic        i_load,       // capture a new instruction
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;

    // Pipeline register update with flush > load > clear > hold priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_inst     <= INST_NOP;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_inst  <= INST_NOP;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_inst     <= i_inst;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_inst     = r_inst;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule : if_id_register
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage. Owns the PC, addresses instruction memory
//                combinationally and fills the IF/ID register. Handles stall,
//                branch/jump redirect, halt word and out-of-range fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,              // synchronous, active-low
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] inst,
    output logic [31:0] read_address,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted,
    output logic        fetch_error
);

    localparam logic [31:0] c_mem_bytes = 32'(MEM_BYTES);
    localparam logic [31:0] c_last_pc   = c_mem_bytes - WORD_BYTES;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_plus4;
    logic         r_halted;
    logic         w_halted_next;
    logic         r_fetch_error;
    logic         w_fetch_error_next;
    logic         w_load;
    logic         w_flush;
    logic         w_clear;
    logic         w_target_legal;

    assign w_pc_plus4     = r_pc + WORD_BYTES;
    assign w_target_legal = (redirect_target[1:0] == 2'b00) &&
                            (redirect_target < c_mem_bytes);

    // State, PC and sticky status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_fetch_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_halted      <= w_halted_next;
            r_fetch_error <= w_fetch_error_next;
        end
    end

    // Next-state and IF/ID control; RUN checks are in strict priority order.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_halted_next      = r_halted;
        w_fetch_error_next = r_fetch_error;
        w_load             = 1'b0;
        w_flush            = 1'b0;
        w_clear            = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_clear      = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    if (w_target_legal) begin
                        w_pc_next = redirect_target;
                        w_flush   = 1'b1;
                    end else begin
                        w_fetch_error_next = 1'b1;
                        w_halted_next      = 1'b1;
                        w_state_next       = ST_HALTED;
                        w_clear            = 1'b1;
                    end
                end else if (stall) begin
                    // Hold PC and IF/ID.
                end else if (inst == HALT_WORD) begin
                    w_halted_next = 1'b1;
                    w_state_next  = ST_HALTED;
                    w_clear       = 1'b1;
                end else if (r_pc == c_last_pc) begin
                    // Last word in memory: take it, then stop before leaving.
                    w_load             = 1'b1;
                    w_fetch_error_next = 1'b1;
                    w_halted_next      = 1'b1;
                    w_state_next       = ST_HALTED;
                end else begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc_plus4;
                end
            end
            ST_HALTED: begin
                w_clear = 1'b1;
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = ST_BOOT;
            end
        endcase
    end

    if_id_register u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_flush    (w_flush),
        .i_load     (w_load),
        .i_inst     (inst),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .o_valid    (if_id_valid),
        .o_inst     (if_id_inst),
        .o_pc       (if_id_pc),
        .o_pc_plus4 (if_id_pc_plus4)
    );

    assign read_address = r_pc;
    assign halted       = r_halted;
    assign fetch_error  = r_fetch_error;

endmodule : instruction_fetch
`default_nettype wire
